regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between NREQ writeback sources: ALU pipe, load return, mul/div.
//   Each source gets a small FIFO; a round-robin arbiter drains one write per cycle into registered w_* outputs.
//   Exports a per-register pending bitmap (busy) that the hazard unit uses to stall dependent reads.
//   Sits between the writeback sources and the register file write port (w_ena/w_addr/w_data).
// PARAMETERS
//   NREQ   3  number of writeback requesters (2..4); index 0 = ALU, 1 = LSU, 2 = MDU
//   DEPTH  2  entries per requester FIFO (power of 2, >=2)
// PORTS
//   clk        in   1        clock, all state on posedge
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   NREQ     requester i has a write to offer
//   req_ready  out  NREQ     requester i FIFO not full; transfer when valid&&ready
//   req_addr   in   NREQ*5   dest register, slice [i*5+:5]
//   req_data   in   NREQ*32  write data, slice [i*32+:32]
//   w_ena      out  1        register-file write enable (registered)
//   w_addr     out  5        register-file write address (registered)
//   w_data     out  32       register-file write data (registered)
//   busy       out  32       busy[r]=1: a write to r is queued and not yet on w_*
//   idle       out  1        all FIFOs empty and w_ena=0
// BEHAVIOUR
//   Reset: all FIFOs emptied; w_ena=0, w_addr=0, w_data=0; busy=0; idle=1; RR pointer=NREQ-1 (req0 first).
//   Reset mid-operation discards every queued write; no partial write is issued.
//   req_ready[i] = !full[i]; depends only on the FIFO count, never on same-cycle pop (no pass-through).
//   Enqueue on valid&&ready at edge N; the entry is visible at the FIFO head in cycle N+1.
//   Arbitration (cycle N+1): grant the first non-empty FIFO scanning from pointer+1 upward, wrapping mod NREQ.
//   The granted head is popped at the end of N+1; w_ena/w_addr/w_data are loaded and are valid in cycle N+2.
//   Minimum enqueue-to-write latency: 2 cycles.
//   RR pointer updates to the granted index only when a grant occurs; otherwise it holds.
//   No grant in a cycle -> w_ena=0 next cycle; w_addr/w_data hold their last values.
//   Throughput: one write per cycle total; one enqueue per requester per cycle.
//   Enqueue and pop on the same FIFO in the same cycle: count unchanged, both take effect.
//   A full FIFO with a simultaneous pop still shows ready=0 in that cycle.
//   Address 0 writes: accepted when ready, but never stored (count unchanged), never set busy[0], never drive w_ena.
//   busy[r] = OR over valid entries of all FIFOs with addr==r. busy[0] is always 0.
//   busy excludes the w_* output stage; the register file write-through bypass covers that cycle.
//   Writes to the same register from different requesters: commit order is RR order, not enqueue order.
//   Upstream must use busy to prevent WAW across requesters. Within one requester, order is FIFO.
//   idle is combinational: all counts zero and w_ena=0.
// STRUCTURE
//   Shared defines.v: REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32, requester index constants
//   (WB_REQ_ALU=0, WB_REQ_LSU=1, WB_REQ_MDU=2).
//   Sub-module wb_fifo (params DEPTH, W=37). Ports: push, pop, din, dout, full, empty.
//   wb_fifo exposes its entry addr/valid vectors for the busy compare.
//   Top level: NREQ wb_fifo instances, RR grant logic, output register, busy OR-tree.
// TESTING
//   1) rst then req0 writes r5=0xDEADBEEF at cycle 1 -> busy[5]=1 in cycle 2; w_ena=1, w_addr=5,
//      w_data=0xDEADBEEF in cycle 3; busy[5]=0 in cycle 3.
//   2) All 3 requesters valid every cycle -> w_* source order 0,1,2,0,1,2...; one w_ena per cycle, no gaps.
//   3) req1 sends 3 writes while grants are starved by req0/req2 traffic -> req_ready[1]=0 after 2 accepts;
//      the 3rd write is accepted only after the first pop; commit order within req1 preserved.
//   4) req2 writes r0=0x1234 -> req_ready stays 1, busy[0]=0, no w_ena, idle stays 1.
//   5) Queue 4 writes across FIFOs, assert rst for 1 cycle mid-stream -> w_ena=0, busy=0, idle=1 next cycle;
//      no queued write ever appears afterwards.
//   6) FIFO full and popped the same cycle a new valid arrives -> ready=0 that cycle, accepted the next;
//      data intact.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback queue entry layout
// used by the writeback arbiter and its per-requester FIFOs.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;

    localparam int WB_REQ_ALU = 0;
    localparam int WB_REQ_LSU = 1;
    localparam int WB_REQ_MDU = 2;

    localparam int ENTRY_W = REG_ADDR_W + REG_DATA_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small circular FIFO for one writeback requester; also exposes every slot's
// destination address and occupancy so the top can build the busy bitmap.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                din,
    output logic [W-1:0]                dout,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH*REG_ADDR_W-1:0] entry_addr,
    output logic [DEPTH-1:0]            entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic [PTR_W-1:0] rel;
        assign rel            = PTR_W'(k) - rd_ptr;
        assign entry_valid[k] = ({1'b0, rel} < count);
        assign entry_addr[k*REG_ADDR_W +: REG_ADDR_W] = mem[k][W-1 -: REG_ADDR_W];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NREQ queued writeback sources, plus the pending-write bitmap for hazards.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*REG_DATA_W-1:0] req_data,
    output logic                       w_ena,
    output logic [REG_ADDR_W-1:0]      w_addr,
    output logic [REG_DATA_W-1:0]      w_data,
    output logic [REG_NUM-1:0]         busy,
    output logic                       idle
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int AW    = DEPTH * REG_ADDR_W;

    logic [NREQ-1:0]  full;
    logic [NREQ-1:0]  empty;
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  pop;
    wb_entry_t        head       [NREQ];
    logic [AW-1:0]    fifo_addr  [NREQ];
    logic [DEPTH-1:0] fifo_valid [NREQ];

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_valid;

    assign req_ready = ~full;

    // Writes to r0 are handshaken but dropped here, so they never queue or set busy.
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign push[i] = req_valid[i] && !full[i] &&
                         (req_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0);
        assign pop[i]  = grant_valid && (grant_idx == IDX_W'(i));

        wb_fifo #(
            .DEPTH (DEPTH),
            .W     (ENTRY_W)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push[i]),
            .pop         (pop[i]),
            .din         ({req_addr[i*REG_ADDR_W +: REG_ADDR_W],
                           req_data[i*REG_DATA_W +: REG_DATA_W]}),
            .dout        (head[i]),
            .full        (full[i]),
            .empty       (empty[i]),
            .entry_addr  (fifo_addr[i]),
            .entry_valid (fifo_valid[i])
        );
    end

    // Scan starts one past the last grantee so every requester gets its turn.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'(rr_index(int'(rr_ptr), k, NREQ));
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ena  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            rr_ptr <= IDX_W'(NREQ - 1);
        end else begin
            w_ena <= grant_valid;
            if (grant_valid) begin
                rr_ptr <= grant_idx;
                w_addr <= head[grant_idx].addr;
                w_data <= head[grant_idx].data;
            end
        end
    end

    // The output stage is excluded; the register file bypass covers that cycle.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (fifo_valid[i][k]) busy[fifo_addr[i][k*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    assign idle = (&empty) && !w_ena;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: fixed vector table, directed
// multi-cycle sequences and randomized traffic against a queue-level model.
module tb_regfile_wb_arbiter;

    localparam int NREQ  = 3;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        w_ena;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] busy;
    logic        idle;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .w_ena     (w_ena),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per requester, index of last grantee, and the write port.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [NREQ][$];
    int          m_last;
    logic        m_w_ena;
    logic [4:0]  m_w_addr;
    logic [31:0] m_w_data;

    function automatic void model_reset();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        m_last   = NREQ - 1;
        m_w_ena  = 1'b0;
        m_w_addr = '0;
        m_w_data = '0;
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < NREQ; i++)
            foreach (mq[i][k]) b[mq[i][k].addr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    function automatic logic exp_idle();
        int total;
        total = 0;
        for (int i = 0; i < NREQ; i++) total += mq[i].size();
        return (total == 0) && !m_w_ena;
    endfunction

    function automatic void advance_model(input logic r, input logic [2:0] v,
                                          input logic [14:0] a, input logic [95:0] d);
        int   sz [NREQ];
        int   g;
        int   c;
        ent_t e;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NREQ; i++) sz[i] = mq[i].size();
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (g < 0 && sz[c] > 0) g = c;
        end
        if (g >= 0) begin
            e        = mq[g].pop_front();
            m_w_ena  = 1'b1;
            m_w_addr = e.addr;
            m_w_data = e.data;
            m_last   = g;
        end else begin
            m_w_ena = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && sz[i] < DEPTH && a[i*5 +: 5] != 5'd0)
                mq[i].push_back('{addr: a[i*5 +: 5], data: d[i*32 +: 32]});
        end
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_val({tag, ".ready"},  32'(req_ready), 32'(exp_ready()));
        check_val({tag, ".w_ena"},  32'(w_ena),     32'(m_w_ena));
        check_val({tag, ".w_addr"}, 32'(w_addr),    32'(m_w_addr));
        check_val({tag, ".w_data"}, w_data,         m_w_data);
        check_val({tag, ".busy"},   busy,           exp_busy());
        check_val({tag, ".idle"},   32'(idle),      32'(exp_idle()));
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input string tag, input logic r, input logic [2:0] v,
                                 input logic [14:0] a, input logic [95:0] d);
        rst       = r;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        checkOutput(tag);
        advance_model(r, v, a, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        applyStimulus("reset", 1'b1, 3'b000, '0, '0);
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  e_ready;
        logic        e_w_ena;
        logic [4:0]  e_w_addr;
        logic [31:0] e_w_data;
        logic [31:0] e_busy;
        logic        e_idle;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] r1_log [$];
    bit          r1_collect = 1'b0;

    always @(negedge clk) begin
        if (r1_collect && w_ena === 1'b1 && w_addr === 5'd2) r1_log.push_back(w_data);
    end

    initial begin
        vecs[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF},
                    3'b111, 1'b0, 5'd0, 32'h0,        32'h0,  1'b1};
        vecs[1] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b0, 5'd0, 32'h0,        32'h20, 1'b0};
        vecs[2] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,  1'b0};
        vecs[3] = '{3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'h0, 32'h0},
                    3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,  1'b1};
        vecs[4] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,  1'b1};
        vecs[5] = '{3'b011, {5'd0, 5'd7, 5'd3}, {32'h0, 32'hB, 32'hA},
                    3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,  1'b1};
        vecs[6] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 32'h88, 1'b0};
        vecs[7] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b1, 5'd7, 32'hB,        32'h08, 1'b0};
        vecs[8] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b1, 5'd3, 32'hA,        32'h0,  1'b0};
        vecs[9] = '{3'b000, 15'd0, 96'd0, 3'b111, 1'b0, 5'd3, 32'hA,        32'h0,  1'b1};

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        model_reset();

        // Fixed vectors: single write latency, r0 drop, RR order between two sources.
        for (int n = 0; n < 10; n++) begin
            rst       = 1'b0;
            req_valid = vecs[n].valid;
            req_addr  = vecs[n].addr;
            req_data  = vecs[n].data;
            #1;
            check_val($sformatf("vec%0d.ready", n),  32'(req_ready), 32'(vecs[n].e_ready));
            check_val($sformatf("vec%0d.w_ena", n),  32'(w_ena),     32'(vecs[n].e_w_ena));
            check_val($sformatf("vec%0d.w_addr", n), 32'(w_addr),    32'(vecs[n].e_w_addr));
            check_val($sformatf("vec%0d.w_data", n), w_data,         vecs[n].e_w_data);
            check_val($sformatf("vec%0d.busy", n),   busy,           vecs[n].e_busy);
            check_val($sformatf("vec%0d.idle", n),   32'(idle),      32'(vecs[n].e_idle));
            advance_model(1'b0, vecs[n].valid, vecs[n].addr, vecs[n].data);
            @(negedge clk);
        end

        // All three sources saturated: commits rotate 0,1,2 with no gaps.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) begin
                check_val($sformatf("rr%0d.w_ena", c), 32'(w_ena), 32'd1);
                check_val($sformatf("rr%0d.src", c), 32'(w_data[31:28]), 32'((c - 2) % 3));
            end
            applyStimulus("rr", 1'b0, 3'b111, {5'd10, 5'd9, 5'd8},
                          {4'd2, 28'(c), 4'd1, 28'(c), 4'd0, 28'(c)});
        end

        // Requester 1 fills while starved; full-and-popping still shows not ready.
        do_reset();
        r1_collect = 1'b1;
        applyStimulus("bp0", 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC0, 32'hA1, 32'hB0});
        applyStimulus("bp1", 1'b0, 3'b010, {5'd0, 5'd2, 5'd0}, {32'h0, 32'hA2, 32'h0});
        check_val("bp.ready1_full", 32'(req_ready[1]), 32'd0);
        applyStimulus("bp2", 1'b0, 3'b010, {5'd0, 5'd2, 5'd0}, {32'h0, 32'hA3, 32'h0});
        check_val("bp.ready1_after_pop", 32'(req_ready[1]), 32'd1);
        applyStimulus("bp3", 1'b0, 3'b010, {5'd0, 5'd2, 5'd0}, {32'h0, 32'hA3, 32'h0});
        for (int c = 0; c < 8; c++) applyStimulus("bp_drain", 1'b0, 3'b000, '0, '0);
        r1_collect = 1'b0;
        check_val("bp.r1_count", 32'(r1_log.size()), 32'd3);
        if (r1_log.size() == 3) begin
            check_val("bp.r1_first",  r1_log[0], 32'hA1);
            check_val("bp.r1_second", r1_log[1], 32'hA2);
            check_val("bp.r1_third",  r1_log[2], 32'hA3);
        end

        // Reset in the middle of queued traffic discards everything.
        do_reset();
        applyStimulus("mr0", 1'b0, 3'b111, {5'd6, 5'd5, 5'd4}, {32'h66, 32'h55, 32'h44});
        applyStimulus("mr1", 1'b0, 3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99});
        applyStimulus("mr_rst", 1'b1, 3'b000, '0, '0);
        check_val("mr.w_ena", 32'(w_ena), 32'd0);
        check_val("mr.busy",  busy,       32'd0);
        check_val("mr.idle",  32'(idle),  32'd1);
        for (int c = 0; c < 6; c++) begin
            applyStimulus("mr_after", 1'b0, 3'b000, '0, '0);
            check_val("mr.no_write", 32'(w_ena), 32'd0);
        end

        // Randomized traffic with occasional resets, small address range for overlaps.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic [2:0]  v;
            logic [14:0] a;
            logic [95:0] d;
            r = ($urandom_range(0, 63) == 0);
            v = 3'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                a[i*5 +: 5]  = 5'($urandom_range(0, 12));
                d[i*32 +: 32] = $urandom;
            end
            applyStimulus("rand", r, v, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
